// File: rtl/merge2_leaf_sync.sv
// merge2_leaf_sync: round-robin 2-to-1 merge leaf with a source-tagged output FIFO
// Ports: CLK/RESET (async, active-high); In0_*/In1_* valid/ready input channels;
// Out_data/Out_valid/Out_ready output channel with S = source tag of the head flit.
module merge2_leaf_sync #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] In0_data,
    input  logic         In0_valid,
    output logic         In0_ready,
    input  logic [W-1:0] In1_data,
    input  logic         In1_valid,
    output logic         In1_ready,
    output logic [W-1:0] Out_data,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic         S
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] TOP  = PW'(DEPTH - 1);

    logic [W:0]    mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          last_q, last_d;
    logic          pop, push, grant;

    assign Out_valid     = count_q != '0;
    assign {S, Out_data} = mem_q[rd_q];

    always_comb begin
        pop       = Out_valid && Out_ready;
        // In1 wins only when alone or when In0 had the previous grant.
        grant     = In1_valid && (!In0_valid || !last_q);
        // RESET gating keeps both readies low for the whole reset pulse.
        push      = !RESET && (In0_valid || In1_valid) && ((count_q != FULL) || pop);
        In0_ready = push && !grant;
        In1_ready = push && grant;
        last_d    = push ? grant : last_q;
        rd_d      = pop ? (rd_q == TOP ? '0 : rd_q + 1'b1) : rd_q;
        wr_d      = push ? (wr_q == TOP ? '0 : wr_q + 1'b1) : wr_q;
        count_d   = (push && !pop) ? count_q + 1'b1 :
                    (pop && !push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            last_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            if (push) mem_q[wr_q] <= {grant, grant ? In1_data : In0_data};
        end
    end
endmodule
